// File: rtl/jk_bank_sequencer_pkg.sv
// Shared encodings and default sizes for the JK bank sequencer slice.
package jk_bank_sequencer_pkg;

    localparam int WIDTH_DEF  = 4;
    localparam int STEP_W_DEF = 8;

    typedef enum logic [1:0] {
        MODE_LOAD   = 2'b00,
        MODE_UP     = 2'b01,
        MODE_DOWN   = 2'b10,
        MODE_TOGGLE = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/jk_bank_sequencer_if.sv
// Command/status bundle between a command source and the JK bank sequencer.
interface jk_bank_sequencer_if
    import jk_bank_sequencer_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int STEP_W = STEP_W_DEF
);
    logic              START;
    logic [1:0]        MODE;
    logic [WIDTH-1:0]  DIN;
    logic [STEP_W-1:0] STEPS;
    logic              PAUSE;
    logic [WIDTH-1:0]  J_O;
    logic [WIDTH-1:0]  K_O;
    logic [WIDTH-1:0]  Q;
    logic [WIDTH-1:0]  Q_n;
    logic              BUSY;
    logic              DONE;

    modport master (
        output START, MODE, DIN, STEPS, PAUSE,
        input  J_O, K_O, Q, Q_n, BUSY, DONE
    );

    modport slave (
        input  START, MODE, DIN, STEPS, PAUSE,
        output J_O, K_O, Q, Q_n, BUSY, DONE
    );
endinterface

// File: rtl/jk_bank_sequencer_jk_cell.sv
// Single JK flip-flop; Q_n is derived from the one state bit so it can never disagree with Q.
module jk_cell (
    input  logic CLK,
    input  logic RST_n,
    input  logic J,
    input  logic K,
    output logic Q,
    output logic Q_n
);
    logic q_r;

    // JK next-state rule with asynchronous clear
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            q_r <= 1'b0;
        end else begin
            case ({J, K})
                2'b00:   q_r <= q_r;
                2'b01:   q_r <= 1'b0;
                2'b10:   q_r <= 1'b1;
                2'b11:   q_r <= ~q_r;
                default: q_r <= q_r;
            endcase
        end
    end

    assign Q   = q_r;
    assign Q_n = ~q_r;
endmodule

// File: rtl/jk_bank_sequencer.sv
// Sequencer that turns single-shot commands into per-cycle J/K drive for a bank of JK cells.
module jk_bank_sequencer
    import jk_bank_sequencer_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int STEP_W = STEP_W_DEF
) (
    input  logic              CLK,
    input  logic              RST_n,
    jk_bank_sequencer_if.slave bus
);
    localparam logic [STEP_W-1:0] STEP_ONE = {{(STEP_W-1){1'b0}}, 1'b1};

    state_e            state_r;
    mode_e             mode_r;
    logic [WIDTH-1:0]  din_r;
    logic [STEP_W-1:0] cnt_r;
    logic              busy_r;
    logic              done_r;

    logic [WIDTH-1:0]  q_s;
    logic [WIDTH-1:0]  qn_s;
    logic [WIDTH-1:0]  up_s;
    logic [WIDTH-1:0]  dn_s;
    logic [WIDTH-1:0]  j_s;
    logic [WIDTH-1:0]  k_s;
    logic              update_s;

    // Ripple-carry/borrow enables: bit i flips when every lower bit is 1 (up) or 0 (down)
    assign up_s[0] = 1'b1;
    assign dn_s[0] = 1'b1;
    for (genvar i = 1; i < WIDTH; i++) begin : g_carry
        assign up_s[i] = &q_s[i-1:0];
        assign dn_s[i] = &qn_s[i-1:0];
    end

    // Drive is live only on an unpaused RUN cycle with steps remaining
    always_comb begin
        update_s = 1'b0;
        if ((state_r == ST_RUN) && !bus.PAUSE && (cnt_r != {STEP_W{1'b0}})) begin
            update_s = 1'b1;
        end else begin
            update_s = 1'b0;
        end
    end

    // Per-mode J/K pattern presented to the cells
    always_comb begin
        j_s = {WIDTH{1'b0}};
        k_s = {WIDTH{1'b0}};
        if (update_s) begin
            case (mode_r)
                MODE_LOAD:   begin j_s = din_r; k_s = ~din_r; end
                MODE_UP:     begin j_s = up_s;  k_s = up_s;   end
                MODE_DOWN:   begin j_s = dn_s;  k_s = dn_s;   end
                MODE_TOGGLE: begin j_s = din_r; k_s = din_r;  end
                default:     begin j_s = {WIDTH{1'b0}}; k_s = {WIDTH{1'b0}}; end
            endcase
        end else begin
            j_s = {WIDTH{1'b0}};
            k_s = {WIDTH{1'b0}};
        end
    end

    // Command FSM, step counter and registered BUSY/DONE
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_r <= ST_IDLE;
            mode_r  <= MODE_LOAD;
            din_r   <= {WIDTH{1'b0}};
            cnt_r   <= {STEP_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.START) begin
                        mode_r  <= mode_e'(bus.MODE);
                        din_r   <= bus.DIN;
                        // a load is always exactly one update regardless of STEPS
                        cnt_r   <= (bus.MODE == MODE_LOAD) ? STEP_ONE : bus.STEPS;
                        state_r <= ST_RUN;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (cnt_r == {STEP_W{1'b0}}) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else if (!bus.PAUSE) begin
                        cnt_r <= cnt_r - STEP_ONE;
                        if (cnt_r == STEP_ONE) begin
                            state_r <= ST_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .CLK   (CLK),
            .RST_n (RST_n),
            .J     (j_s[i]),
            .K     (k_s[i]),
            .Q     (q_s[i]),
            .Q_n   (qn_s[i])
        );
    end

    assign bus.J_O  = j_s;
    assign bus.K_O  = k_s;
    assign bus.Q    = q_s;
    assign bus.Q_n  = qn_s;
    assign bus.BUSY = busy_r;
    assign bus.DONE = done_r;
endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Directed bench for jk_bank_sequencer: linear command sequence with hand-computed bank values.
module tb_jk_bank_sequencer;
    import jk_bank_sequencer_pkg::*;

    logic CLK;
    logic RST_n;
    int   n_total;
    int   n_pass;
    int   n_fail;

    jk_bank_sequencer_if #(.WIDTH(4), .STEP_W(8)) bus ();

    jk_bank_sequencer #(.WIDTH(4), .STEP_W(8)) dut (
        .CLK   (CLK),
        .RST_n (RST_n),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse START for one edge; returns on the negedge after the latch edge (state RUN)
    task automatic start_cmd(input logic [1:0] mode, input logic [3:0] din, input logic [7:0] steps);
        bus.START = 1'b1;
        bus.MODE  = mode;
        bus.DIN   = din;
        bus.STEPS = steps;
        @(negedge CLK);
        bus.START = 1'b0;
    endtask

    task automatic do_load(input logic [3:0] din);
        start_cmd(2'b00, din, 8'd0);
        @(negedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        n_total = 0; n_pass = 0; n_fail = 0;
        RST_n = 1'b0;
        bus.START = 1'b0; bus.MODE = 2'b00; bus.DIN = 4'h0; bus.STEPS = 8'd0; bus.PAUSE = 1'b0;
        #1;
        chk("rst_q",    32'(bus.Q),    32'h0);
        chk("rst_qn",   32'(bus.Q_n),  32'hF);
        chk("rst_busy", 32'(bus.BUSY), 32'h0);
        chk("rst_done", 32'(bus.DONE), 32'h0);
        chk("rst_j",    32'(bus.J_O),  32'h0);
        @(negedge CLK);
        RST_n = 1'b1;
        @(negedge CLK);

        // Load 1010
        start_cmd(2'b00, 4'b1010, 8'd7);
        chk("ld_busy", 32'(bus.BUSY), 32'h1);
        chk("ld_j",    32'(bus.J_O),  32'hA);
        chk("ld_k",    32'(bus.K_O),  32'h5);
        @(negedge CLK);
        chk("ld_q",     32'(bus.Q),    32'hA);
        chk("ld_qn",    32'(bus.Q_n),  32'h5);
        chk("ld_done",  32'(bus.DONE), 32'h1);
        chk("ld_busy0", 32'(bus.BUSY), 32'h0);
        @(negedge CLK);
        chk("ld_done0", 32'(bus.DONE), 32'h0);

        // Asynchronous reset mid-cycle
        #2 RST_n = 1'b0;
        #1;
        chk("arst_q",  32'(bus.Q),   32'h0);
        chk("arst_qn", 32'(bus.Q_n), 32'hF);
        @(negedge CLK);
        RST_n = 1'b1;
        @(negedge CLK);

        // Count up 1110 -> 1111, 0000, 0001
        do_load(4'b1110);
        chk("pre_up_q", 32'(bus.Q), 32'hE);
        start_cmd(2'b01, 4'h0, 8'd3);
        chk("up_j", 32'(bus.J_O), 32'h1);
        @(negedge CLK);
        chk("up_q1",    32'(bus.Q),    32'hF);
        chk("up_busy1", 32'(bus.BUSY), 32'h1);
        chk("up_done1", 32'(bus.DONE), 32'h0);
        @(negedge CLK);
        chk("up_q2", 32'(bus.Q), 32'h0);
        @(negedge CLK);
        chk("up_q3",    32'(bus.Q),    32'h1);
        chk("up_done3", 32'(bus.DONE), 32'h1);
        chk("up_busy3", 32'(bus.BUSY), 32'h0);
        @(negedge CLK);

        // Count down 0001 with two paused edges after the first update
        start_cmd(2'b10, 4'h0, 8'd3);
        chk("dn_j0", 32'(bus.J_O), 32'h1);
        @(negedge CLK);
        chk("dn_q1", 32'(bus.Q), 32'h0);
        bus.PAUSE = 1'b1;
        #1;
        chk("dn_pause_j", 32'(bus.J_O), 32'h0);
        @(negedge CLK);
        chk("dn_hold1", 32'(bus.Q),    32'h0);
        chk("dn_busyp", 32'(bus.BUSY), 32'h1);
        @(negedge CLK);
        chk("dn_hold2", 32'(bus.Q),    32'h0);
        chk("dn_busyq", 32'(bus.BUSY), 32'h1);
        bus.PAUSE = 1'b0;
        #1;
        chk("dn_j1", 32'(bus.J_O), 32'hF);
        @(negedge CLK);
        chk("dn_q2", 32'(bus.Q), 32'hF);
        // START with a different mode while RUN must be ignored
        bus.START = 1'b1; bus.MODE = 2'b01; bus.DIN = 4'h9; bus.STEPS = 8'd5;
        @(negedge CLK);
        chk("dn_q3",   32'(bus.Q),    32'hE);
        chk("dn_done", 32'(bus.DONE), 32'h1);
        bus.START = 1'b0;
        @(negedge CLK);
        chk("ign_busy", 32'(bus.BUSY), 32'h0);
        chk("ign_q",    32'(bus.Q),    32'hE);
        @(negedge CLK);
        chk("ign_q2",   32'(bus.Q),    32'hE);

        // Masked toggle then STEPS=0
        do_load(4'b0000);
        start_cmd(2'b11, 4'b0110, 8'd2);
        chk("tg_j", 32'(bus.J_O), 32'h6);
        chk("tg_k", 32'(bus.K_O), 32'h6);
        @(negedge CLK);
        chk("tg_q1", 32'(bus.Q), 32'h6);
        @(negedge CLK);
        chk("tg_q2",   32'(bus.Q),    32'h0);
        chk("tg_done", 32'(bus.DONE), 32'h1);
        @(negedge CLK);
        start_cmd(2'b11, 4'b0110, 8'd0);
        chk("z_busy", 32'(bus.BUSY), 32'h1);
        chk("z_j",    32'(bus.J_O),  32'h0);
        @(negedge CLK);
        chk("z_done",  32'(bus.DONE), 32'h1);
        chk("z_busy0", 32'(bus.BUSY), 32'h0);
        chk("z_q",     32'(bus.Q),    32'h0);
        @(negedge CLK);
        chk("z_done0", 32'(bus.DONE), 32'h0);

        // Abort mid-count with reset, then accept a new command
        start_cmd(2'b01, 4'h0, 8'd5);
        @(negedge CLK);
        chk("ab_q1", 32'(bus.Q), 32'h1);
        @(negedge CLK);
        chk("ab_q2", 32'(bus.Q), 32'h2);
        #2 RST_n = 1'b0;
        #1;
        chk("ab_q",    32'(bus.Q),    32'h0);
        chk("ab_busy", 32'(bus.BUSY), 32'h0);
        @(negedge CLK);
        chk("ab_done", 32'(bus.DONE), 32'h0);
        RST_n = 1'b1;
        @(negedge CLK);
        start_cmd(2'b00, 4'b0101, 8'd0);
        chk("re_busy", 32'(bus.BUSY), 32'h1);
        @(negedge CLK);
        chk("re_q",    32'(bus.Q),    32'h5);
        chk("re_done", 32'(bus.DONE), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
